// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the cdc_fifo read-side stream reader.
// Holds the reader state encoding, skid depth and the skid occupancy helper.
package cdc_fifo_pkg;

  typedef enum logic [0:0] {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } reader_state_t;

  localparam int SKID_DEPTH = 2;
  localparam logic [1:0] SKID_FULL_COUNT = 2'(SKID_DEPTH);

  // Occupancy after one cycle; a simultaneous push and pop leaves it unchanged.
  function automatic logic [1:0] skid_next_count(input logic [1:0] count,
                                                 input logic push,
                                                 input logic pop);
    logic [1:0] result;
    result = count;
    if (push && !pop) begin
      result = count + 2'd1;
    end else if (!push && pop) begin
      result = count - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cdc_fifo_skid_buffer.sv
// Two-entry register FIFO that backs the reader's output stream.
// entry0 is always the oldest word, so the head is a plain register output.
module cdc_fifo_skid_buffer
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  do_pop;
  logic                  do_push;
  logic                  write_slot0;

  assign do_pop      = pop && (count != 2'd0);
  assign do_push     = push && ((count < SKID_FULL_COUNT) || do_pop);
  assign write_slot0 = (count == 2'd0) || ((count == 2'd1) && do_pop);
  assign head_data   = entry0;

  // Shift on pop first; a same-cycle push then lands in the freed tail slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      count <= skid_next_count(count, do_push, do_pop);
      if (do_pop) begin
        entry0 <= entry1;
      end
      if (do_push) begin
        if (write_slot0) begin
          entry0 <= push_data;
        end else begin
          entry1 <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_stream_reader.sv
// Read-side consumer of cdc_fifo: pops the FIFO into a skid buffer and offers
// the words as a valid/ready stream, with a flush mode and word counters.
module cdc_fifo_stream_reader
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  output logic                   fifo_read_increment,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   flush_busy,
  output logic [COUNT_WIDTH-1:0] words_delivered,
  output logic [COUNT_WIDTH-1:0] words_dropped
);

  reader_state_t        state;
  reader_state_t        next_state;
  logic [1:0]           buf_cnt;
  logic [DATA_WIDTH-1:0] head_data;
  logic                 pop;
  logic                 handshake;
  logic                 buf_push;
  logic                 buf_pop;
  logic                 buf_clear;
  logic                 delivered_inc;
  logic [1:0]           drop_add;
  logic [COUNT_WIDTH:0] dropped_sum;

  cdc_fifo_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (buf_push),
    .push_data(fifo_read_data),
    .pop      (buf_pop),
    .clear    (buf_clear),
    .head_data(head_data),
    .count    (buf_cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= STREAM;
    end else begin
      state <= next_state;
    end
  end

  // A flush wins over any handshake that cycle; everything buffered, plus a word
  // popped on that same edge, is counted as dropped rather than delivered.
  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    handshake     = 1'b0;
    out_valid     = 1'b0;
    flush_busy    = 1'b0;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_clear     = 1'b0;
    delivered_inc = 1'b0;
    drop_add      = 2'd0;
    case (state)
      STREAM: begin
        out_valid = (buf_cnt != 2'd0);
        handshake = out_valid && out_ready;
        pop       = !fifo_empty && ((buf_cnt < SKID_FULL_COUNT) || handshake);
        if (flush) begin
          next_state = FLUSH;
          buf_clear  = 1'b1;
          drop_add   = buf_cnt + {1'b0, pop};
        end else begin
          buf_push      = pop;
          buf_pop       = handshake;
          delivered_inc = handshake;
        end
      end
      FLUSH: begin
        flush_busy = 1'b1;
        pop        = !fifo_empty;
        drop_add   = {1'b0, pop};
        if (fifo_empty) begin
          next_state = STREAM;
        end
      end
      default: begin
        next_state = STREAM;
      end
    endcase
  end

  assign fifo_read_increment = pop && reset_n;
  assign out_data            = head_data;
  assign dropped_sum         = {1'b0, words_dropped} + {{(COUNT_WIDTH-1){1'b0}}, drop_add};

  // Delivered wraps naturally; dropped clamps at all-ones even for multi-word adds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      words_delivered <= '0;
      words_dropped   <= '0;
    end else begin
      words_delivered <= words_delivered + {{(COUNT_WIDTH-1){1'b0}}, delivered_inc};
      if (dropped_sum[COUNT_WIDTH]) begin
        words_dropped <= '1;
      end else begin
        words_dropped <= dropped_sum[COUNT_WIDTH-1:0];
      end
    end
  end

endmodule
